arb_req_buf: RTL and testbench

ARB_REQ_BUF -- requirements
Module: arb_req_buf

---
 rtl/arb_req_buf.sv | 135 +++++++++++++
 tb/tb_arb_req_buf.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/arb_req_buf.sv
// Request buffer between the core arbiter and the memory write port: an in-order
// FIFO of {addr, data, core index} with a registered write-complete ack.
// Optional same-cycle bypass on an empty buffer is enabled by ARB_REQ_BUF_BYPASS_EN.
module arb_req_buf #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 3,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         InVld,
  input  logic [ADDR_WIDTH-1:0]        InAddr,
  input  logic [DATA_WIDTH-1:0]        InDat,
  input  logic [IDX_WIDTH-1:0]         InIdx,
  output logic                         InRdy,
  output logic                         OutVld,
  output logic [ADDR_WIDTH-1:0]        OutAddr,
  output logic [DATA_WIDTH-1:0]        OutDat,
  output logic [IDX_WIDTH-1:0]         OutIdx,
  input  logic                         OutRdy,
  output logic                         AckVld,
  output logic [IDX_WIDTH-1:0]         AckIdx,
  output logic [$clog2(DEPTH):0]       Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ack_vld_q, ack_vld_d;
  logic [IDX_WIDTH-1:0]  ack_idx_q, ack_idx_d;

  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_dat  [DEPTH];
  logic [IDX_WIDTH-1:0]  mem_idx  [DEPTH];

  logic                  empty_s;
  logic                  full_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  xfer_s;

  assign empty_s = (count_q == {CW{1'b0}});
  assign full_s  = (count_q == FULL_C);
  assign InRdy   = !full_s;
  assign pop_s   = !empty_s & OutRdy;
  assign xfer_s  = OutVld & OutRdy;

`ifdef ARB_REQ_BUF_BYPASS_EN
  logic byp_s;

  // An empty buffer forwards the request straight through when memory is ready.
  assign byp_s   = empty_s & InVld & OutRdy;
  assign push_s  = InVld & !full_s & !byp_s;
  assign OutVld  = !empty_s | InVld;
  assign OutAddr = empty_s ? InAddr : mem_addr[rd_ptr_q];
  assign OutDat  = empty_s ? InDat  : mem_dat[rd_ptr_q];
  assign OutIdx  = empty_s ? InIdx  : mem_idx[rd_ptr_q];
`else
  assign push_s  = InVld & !full_s;
  assign OutVld  = !empty_s;
  assign OutAddr = mem_addr[rd_ptr_q];
  assign OutDat  = mem_dat[rd_ptr_q];
  assign OutIdx  = mem_idx[rd_ptr_q];
`endif

  // Pointer and occupancy next state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Ack pulses for one cycle after each transfer; the index is held otherwise.
  always_comb begin
    ack_vld_d = 1'b0;
    ack_idx_d = ack_idx_q;
    if (xfer_s) begin
      ack_vld_d = 1'b1;
      ack_idx_d = OutIdx;
    end else begin
      ack_vld_d = 1'b0;
    end
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= {PW{1'b0}};
      rd_ptr_q  <= {PW{1'b0}};
      count_q   <= {CW{1'b0}};
      ack_vld_q <= 1'b0;
      ack_idx_q <= {IDX_WIDTH{1'b0}};
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ack_vld_q <= ack_vld_d;
      ack_idx_q <= ack_idx_d;
    end
  end

  // Entry storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_addr[wr_ptr_q] <= InAddr;
      mem_dat[wr_ptr_q]  <= InDat;
      mem_idx[wr_ptr_q]  <= InIdx;
    end
  end

  assign Count  = count_q;
  assign AckVld = ack_vld_q;
  assign AckIdx = ack_idx_q;

endmodule

// File: tb/tb_arb_req_buf.sv
// Directed bench for arb_req_buf (DEPTH=4): reset, fill, ordered drain, simultaneous
// push/pop, wrap-around, mid-operation reset, and the bypass or non-bypass boundary.
module tb_arb_req_buf;

  logic        clk;
  logic        rst_n;
  logic        InVld;
  logic [15:0] InAddr;
  logic [15:0] InDat;
  logic [2:0]  InIdx;
  logic        InRdy;
  logic        OutVld;
  logic [15:0] OutAddr;
  logic [15:0] OutDat;
  logic [2:0]  OutIdx;
  logic        OutRdy;
  logic        AckVld;
  logic [2:0]  AckIdx;
  logic [2:0]  Count;

  int total;
  int bad;

  arb_req_buf #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .IDX_WIDTH(3), .DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .InVld(InVld), .InAddr(InAddr), .InDat(InDat), .InIdx(InIdx), .InRdy(InRdy),
    .OutVld(OutVld), .OutAddr(OutAddr), .OutDat(OutDat), .OutIdx(OutIdx), .OutRdy(OutRdy),
    .AckVld(AckVld), .AckIdx(AckIdx), .Count(Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] d,
                       input logic [2:0] i, input logic r);
    InVld  = v;
    InAddr = a;
    InDat  = d;
    InIdx  = i;
    OutRdy = r;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
    #10;
    chk("rst_inrdy",  32'(InRdy),  32'd1);
    chk("rst_outvld", 32'(OutVld), 32'd0);
    chk("rst_ackvld", 32'(AckVld), 32'd0);
    chk("rst_count",  32'(Count),  32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Fill to full with memory stalled
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h100 + 16'(i), 16'h5000 + 16'(i), 3'(i), 1'b0);
      step();
      chk("fill_count", 32'(Count), 32'(i + 1));
    end
    chk("full_inrdy",  32'(InRdy),   32'd0);
    chk("full_head",   32'(OutAddr), 32'h100);
    drive(1'b1, 16'h1FF, 16'hDEAD, 3'd7, 1'b0);
    step();
    chk("full_refuse_count", 32'(Count),   32'd4);
    chk("stall_stable_addr", 32'(OutAddr), 32'h100);
    chk("stall_stable_idx",  32'(OutIdx),  32'd0);

    // Push+pop while full: pop happens, push refused
    drive(1'b1, 16'h1FF, 16'hDEAD, 3'd7, 1'b1);
    step();
    chk("full_pp_count", 32'(Count),   32'd3);
    chk("full_pp_ack",   32'(AckVld),  32'd1);
    chk("full_pp_ackix", 32'(AckIdx),  32'd0);
    chk("full_pp_head",  32'(OutAddr), 32'h101);
    drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b1);
    for (int i = 1; i < 4; i++) begin
      chk("drain1_addr", 32'(OutAddr), 32'h100 + 32'(i));
      chk("drain1_dat",  32'(OutDat),  32'h5000 + 32'(i));
      step();
      chk("drain1_ackix", 32'(AckIdx), 32'(i));
    end
    chk("drain1_empty", 32'(OutVld), 32'd0);
    chk("drain1_count", 32'(Count),  32'd0);

    // Ordered drain: idx 2,5,1 at addr 0x10,0x20,0x30
    drive(1'b1, 16'h10, 16'h0A10, 3'd2, 1'b0); step();
    drive(1'b1, 16'h20, 16'h0A20, 3'd5, 1'b0); step();
    chk("ord_ack_idle", 32'(AckVld), 32'd0);
    drive(1'b1, 16'h30, 16'h0A30, 3'd1, 1'b0); step();
    chk("ord_count", 32'(Count), 32'd3);
    drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b1);
    chk("ord0_addr", 32'(OutAddr), 32'h10);
    chk("ord0_idx",  32'(OutIdx),  32'd2);
    step();
    chk("ord0_ack",   32'(AckVld),  32'd1);
    chk("ord0_ackix", 32'(AckIdx),  32'd2);
    chk("ord1_addr",  32'(OutAddr), 32'h20);
    chk("ord1_idx",   32'(OutIdx),  32'd5);
    step();
    chk("ord1_ack",   32'(AckVld),  32'd1);
    chk("ord1_ackix", 32'(AckIdx),  32'd5);
    chk("ord2_addr",  32'(OutAddr), 32'h30);
    chk("ord2_idx",   32'(OutIdx),  32'd1);
    step();
    chk("ord2_ack",   32'(AckVld),  32'd1);
    chk("ord2_ackix", 32'(AckIdx),  32'd1);
    chk("ord_empty",  32'(OutVld),  32'd0);
    step();
    chk("ord_ack_done",  32'(AckVld), 32'd0);
    chk("ord_ackix_hold", 32'(AckIdx), 32'd1);

    // Simultaneous push/pop at Count=2
    drive(1'b1, 16'h41, 16'h0B41, 3'd3, 1'b0); step();
    drive(1'b1, 16'h42, 16'h0B42, 3'd4, 1'b0); step();
    drive(1'b1, 16'h43, 16'h0B43, 3'd6, 1'b1); step();
    chk("pp2_count", 32'(Count),   32'd2);
    chk("pp2_ackix", 32'(AckIdx),  32'd3);
    chk("pp2_head",  32'(OutAddr), 32'h42);
    drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b1); step();
    chk("pp2_next",  32'(OutAddr), 32'h43);
    step();
    chk("pp2_count0", 32'(Count), 32'd0);

    // Wrap-around: one entry in flight, ten push+pop cycles
    drive(1'b1, 16'h200, 16'hA000, 3'd0, 1'b0); step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'h201 + 16'(i), 16'hA001 + 16'(i), 3'((i + 1) % 8), 1'b1);
      chk("wrap_dat", 32'(OutDat), 32'hA000 + 32'(i));
      step();
      chk("wrap_count", 32'(Count), 32'd1);
    end
    drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b1);
    chk("wrap_last", 32'(OutDat), 32'hA00A);
    step();
    chk("wrap_empty", 32'(Count), 32'd0);

    // Mid-operation reset with Count=3
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h300 + 16'(i), 16'hC000 + 16'(i), 3'(i + 2), 1'b0);
      step();
    end
    chk("mr_pre_count", 32'(Count), 32'd3);
    drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mr_count",  32'(Count),  32'd0);
    chk("mr_outvld", 32'(OutVld), 32'd0);
    chk("mr_inrdy",  32'(InRdy),  32'd1);
    chk("mr_ackix",  32'(AckIdx), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("mr_post_ack",    32'(AckVld), 32'd0);
    chk("mr_post_outvld", 32'(OutVld), 32'd0);
    chk("mr_post_count",  32'(Count),  32'd0);

`ifdef ARB_REQ_BUF_BYPASS_EN
    drive(1'b1, 16'h0400, 16'hBEEF, 3'd6, 1'b1);
    chk("byp_outvld", 32'(OutVld), 32'd1);
    chk("byp_outdat", 32'(OutDat), 32'hBEEF);
    chk("byp_outidx", 32'(OutIdx), 32'd6);
    step();
    drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
    chk("byp_count", 32'(Count),  32'd0);
    chk("byp_ack",   32'(AckVld), 32'd1);
    chk("byp_ackix", 32'(AckIdx), 32'd6);
`else
    drive(1'b1, 16'h0400, 16'hBEEF, 3'd6, 1'b1);
    chk("nobyp_outvld", 32'(OutVld), 32'd0);
    step();
    drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
    chk("nobyp_count",  32'(Count),  32'd1);
    chk("nobyp_ack",    32'(AckVld), 32'd0);
    chk("nobyp_outdat", 32'(OutDat), 32'hBEEF);
    chk("nobyp_outvld1", 32'(OutVld), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
